// File: rtl/cmp_requester.sv
`default_nettype none
// ============================================================================
// Module   : cmp_requester
// Purpose  : Request-side controller for the registered comparator unit.
//            Accepts one compare request at a time, pulses the comparator
//            enable for one cycle, waits for the registered flag (bounded by
//            a watchdog) and returns a decoded boolean answer.
// Options  : CMP_REQ_STATS_EN adds saturating 8-bit response counters
//            (stat_true, stat_false, stat_err).
// Revision : 1.0 - initial release
// ============================================================================
module cmp_requester #(
  parameter int IN_WIDTH = 16,
  parameter int TIMEOUT  = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IN_WIDTH-1:0] req_a,
  input  logic [IN_WIDTH-1:0] req_b,
  input  logic [1:0]          req_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_result,
  output logic [1:0]          rsp_code,
  output logic                rsp_err,
  output logic [IN_WIDTH-1:0] cmp_A,
  output logic [IN_WIDTH-1:0] cmp_B,
  output logic [1:0]          cmp_OP,
  output logic                cmp_enable,
  input  logic [1:0]          cmp_out,
  input  logic                cmp_flag
`ifdef CMP_REQ_STATS_EN
  ,
  output logic [7:0]          stat_true,
  output logic [7:0]          stat_false,
  output logic [7:0]          stat_err
`endif
);

  // Watchdog limit; TIMEOUT is restricted to 1..15 so 4 bits suffice.
  localparam logic [3:0] c_TIMEOUT = TIMEOUT[3:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [IN_WIDTH-1:0]   r_a;
  logic [IN_WIDTH-1:0]   r_b;
  logic [1:0]            r_op;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_inc;
  logic [1:0]            r_rsp_code;
  logic                  r_rsp_err;
  logic                  r_rsp_result;

  logic                  w_accept;
  logic                  w_capture;
  logic                  w_timeout;
  logic                  w_count;
  logic                  w_handshake;

  assign w_cnt_inc = r_cnt + 4'd1;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake/enable outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    cmp_enable  = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_count     = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmp_enable  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cmp_flag) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_cnt_inc == c_TIMEOUT) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_count     = 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, watchdog counter and response capture/decode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 2'b00;
      r_cnt        <= 4'd0;
      r_rsp_code   <= 2'b00;
      r_rsp_err    <= 1'b0;
      r_rsp_result <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a  <= req_a;
        r_b  <= req_b;
        r_op <= req_op;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= 4'd0;
      end else if (w_count) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_capture) begin
        // A no-op never reports a comparator code, whatever it returned.
        r_rsp_code   <= (r_op == 2'b00) ? 2'b00 : cmp_out;
        r_rsp_err    <= 1'b0;
        r_rsp_result <= (r_op != 2'b00) && (cmp_out == r_op);
      end else if (w_timeout) begin
        r_rsp_code   <= 2'b00;
        r_rsp_err    <= 1'b1;
        r_rsp_result <= 1'b0;
      end
    end
  end

  assign cmp_A      = r_a;
  assign cmp_B      = r_b;
  assign cmp_OP     = r_op;
  assign rsp_code   = r_rsp_code;
  assign rsp_err    = r_rsp_err;
  assign rsp_result = r_rsp_result;

`ifdef CMP_REQ_STATS_EN
  logic [7:0] r_stat_true;
  logic [7:0] r_stat_false;
  logic [7:0] r_stat_err;

  // Saturating response counters, stepped on the response handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stat_true  <= 8'd0;
      r_stat_false <= 8'd0;
      r_stat_err   <= 8'd0;
    end else if (w_handshake) begin
      if (r_rsp_err) begin
        if (r_stat_err != 8'hFF) r_stat_err <= r_stat_err + 8'd1;
      end else if (r_rsp_result) begin
        if (r_stat_true != 8'hFF) r_stat_true <= r_stat_true + 8'd1;
      end else begin
        if (r_stat_false != 8'hFF) r_stat_false <= r_stat_false + 8'd1;
      end
    end
  end

  assign stat_true  = r_stat_true;
  assign stat_false = r_stat_false;
  assign stat_err   = r_stat_err;
`else
  // Handshake strobe only feeds the optional counters.
  logic w_unused;
  assign w_unused = w_handshake;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_requester
// Purpose  : Directed self-checking bench for cmp_requester, including a
//            behavioural registered comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_requester;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [1:0]  req_op = 2'b00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_result;
  logic [1:0]  rsp_code;
  logic        rsp_err;
  logic [15:0] cmp_A;
  logic [15:0] cmp_B;
  logic [1:0]  cmp_OP;
  logic        cmp_enable;
  logic [1:0]  cmp_out;
  logic        cmp_flag;
`ifdef CMP_REQ_STATS_EN
  logic [7:0]  stat_true;
  logic [7:0]  stat_false;
  logic [7:0]  stat_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_pulses = 0;
  int en_multi = 0;
  int hs_true = 0;
  logic prev_en = 1'b0;
  logic no_flag = 1'b0;

  cmp_requester #(.IN_WIDTH(16), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_code(rsp_code), .rsp_err(rsp_err),
    .cmp_A(cmp_A), .cmp_B(cmp_B), .cmp_OP(cmp_OP), .cmp_enable(cmp_enable),
    .cmp_out(cmp_out), .cmp_flag(cmp_flag)
`ifdef CMP_REQ_STATS_EN
    , .stat_true(stat_true), .stat_false(stat_false), .stat_err(stat_err)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [1:0] cmp_model(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op);
    case (op)
      2'b01:   return (a == b) ? 2'b01 : 2'b00;
      2'b10:   return (a > b)  ? 2'b10 : 2'b00;
      2'b11:   return (a < b)  ? 2'b11 : 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  // Registered comparator: result and flag appear one edge after enable.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmp_out  <= 2'b00;
      cmp_flag <= 1'b0;
    end else begin
      cmp_flag <= cmp_enable && !no_flag;
      if (cmp_enable) cmp_out <= cmp_model(cmp_A, cmp_B, cmp_OP);
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Enable pulse and true-response handshake monitors.
  always @(negedge CLK) begin
    if (cmp_enable) en_pulses <= en_pulses + 1;
    if (cmp_enable && prev_en) en_multi <= en_multi + 1;
    prev_en <= cmp_enable;
    if (rsp_valid && rsp_ready && rsp_result) hs_true <= hs_true + 1;
  end

  // Present a request at the current negedge; returns at the negedge after accept.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    req_valid = 1'b0;
  endtask

  // Count edges until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge CLK); lat++; @(negedge CLK);
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_code, rsp_err, cmp_OP, cmp_enable} !== 9'b1_0_0_00_0_00_0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 100000000",
               {req_ready, rsp_valid, rsp_result, rsp_code, rsp_err, cmp_OP, cmp_enable});
    end
    checks++;
    if ({cmp_A, cmp_B} !== 32'h0) begin
      errors++; $display("FAIL reset_operands got %h want 00000000", {cmp_A, cmp_B});
    end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_equality();
    int lat;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL eq_ready got %b want 1", req_ready); end
    send(16'h1234, 16'h1234, 2'b01);
    wait_rsp(lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL eq_latency got %0d want 2", lat); end
    checks++;
    if ({rsp_code, rsp_result, rsp_err} !== 4'b01_1_0) begin
      errors++; $display("FAIL eq_data got %b want 0110", {rsp_code, rsp_result, rsp_err});
    end
    ack();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL eq_after_ack got %b want 01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_greater_less();
    int lat;
    send(16'h0005, 16'h0003, 2'b11);
    wait_rsp(lat);
    checks++;
    if ({rsp_valid, rsp_code, rsp_result, rsp_err} !== 5'b1_00_0_0) begin
      errors++; $display("FAIL lt_false got %b want 10000", {rsp_valid, rsp_code, rsp_result, rsp_err});
    end
    ack();
    send(16'h0005, 16'h0003, 2'b10);
    wait_rsp(lat);
    checks++;
    if ({rsp_valid, rsp_code, rsp_result, rsp_err} !== 5'b1_10_1_0) begin
      errors++; $display("FAIL gt_true got %b want 11010", {rsp_valid, rsp_code, rsp_result, rsp_err});
    end
    ack();
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    no_flag = 1'b1;
    send(16'hBEEF, 16'h0001, 2'b10);
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL midwait_busy got %b want 0", req_ready); end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_code, rsp_err, cmp_OP, cmp_enable} !== 9'b1_0_0_00_0_00_0) begin
      errors++;
      $display("FAIL midwait_reset_ctrl got %b want 100000000",
               {req_ready, rsp_valid, rsp_result, rsp_code, rsp_err, cmp_OP, cmp_enable});
    end
    checks++;
    if ({cmp_A, cmp_B} !== 32'h0) begin
      errors++; $display("FAIL midwait_reset_operands got %h want 00000000", {cmp_A, cmp_B});
    end
    @(negedge CLK); RST = 1'b0; no_flag = 1'b0;
    send(16'h00FF, 16'h0100, 2'b11);
    wait_rsp(lat);
    checks++;
    if (lat !== 2 || {rsp_code, rsp_result, rsp_err} !== 4'b11_1_0) begin
      errors++; $display("FAIL post_reset_req got lat %0d data %b want lat 2 data 1110",
                         lat, {rsp_code, rsp_result, rsp_err});
    end
    ack();
  endtask

  task automatic test_backpressure();
    int lat;
    int p0;
    send(16'h0005, 16'h0003, 2'b10);
    wait_rsp(lat);
    req_a = 16'h0007; req_b = 16'h0007; req_op = 2'b01; req_valid = 1'b1;
    p0 = en_pulses;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if ({rsp_valid, req_ready, rsp_result, rsp_code, rsp_err} !== 6'b1_0_1_10_0) begin
        errors++; $display("FAIL bp_hold[%0d] got %b want 101100", i,
                           {rsp_valid, req_ready, rsp_result, rsp_code, rsp_err});
      end
    end
    checks++;
    if (en_pulses !== p0) begin errors++; $display("FAIL bp_no_issue got %0d want %0d", en_pulses, p0); end
    rsp_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, cmp_enable} !== 3'b100) begin
      errors++; $display("FAIL bp_after_hs got %b want 100", {req_ready, rsp_valid, cmp_enable});
    end
    @(posedge CLK); @(negedge CLK);
    req_valid = 1'b0;
    checks++;
    if ({cmp_enable, req_ready, cmp_A, cmp_OP} !== {2'b10, 16'h0007, 2'b01}) begin
      errors++; $display("FAIL bp_second_accept got %b/%b/%h/%b want 1/0/0007/01",
                         cmp_enable, req_ready, cmp_A, cmp_OP);
    end
    wait_rsp(lat);
    checks++;
    if ({rsp_valid, rsp_code, rsp_result, rsp_err} !== 5'b1_01_1_0) begin
      errors++; $display("FAIL bp_second_rsp got %b want 10110", {rsp_valid, rsp_code, rsp_result, rsp_err});
    end
    ack();
  endtask

  task automatic test_timeout();
    int lat;
    no_flag = 1'b1;
    send(16'h1234, 16'h1234, 2'b01);
    wait_rsp(lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL timeout_latency got %0d want 5", lat); end
    checks++;
    if ({rsp_code, rsp_result, rsp_err} !== 4'b00_0_1) begin
      errors++; $display("FAIL timeout_data got %b want 0001", {rsp_code, rsp_result, rsp_err});
    end
    ack();
`ifdef CMP_REQ_STATS_EN
    checks++;
    if (stat_err !== 8'd1) begin errors++; $display("FAIL stat_err got %0d want 1", stat_err); end
`endif
    no_flag = 1'b0;
  endtask

  task automatic test_noop();
    int lat;
    send(16'h0055, 16'h0055, 2'b00);
    wait_rsp(lat);
    checks++;
    if (lat !== 2 || {rsp_code, rsp_result, rsp_err} !== 4'b00_0_0) begin
      errors++; $display("FAIL noop got lat %0d data %b want lat 2 data 0000",
                         lat, {rsp_code, rsp_result, rsp_err});
    end
    ack();
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int n = 0;
    int guard = 0;
    int lat;
    int p0, m0, t0;
    p0 = en_pulses; m0 = en_multi; t0 = hs_true;
    req_a = 16'h0009; req_b = 16'h0009; req_op = 2'b01;
    rsp_ready = 1'b1; req_valid = 1'b1;
    while (n < 3 && guard < 40) begin
      if (req_ready === 1'b1) begin acc[n] = cyc; n++; end
      guard++;
      @(negedge CLK);
    end
    req_valid = 1'b0;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", n); end
    wait_rsp(lat);
    @(posedge CLK); @(negedge CLK);
    rsp_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
      errors++; $display("FAIL b2b_spacing got %0d,%0d want 4,4", acc[1] - acc[0], acc[2] - acc[1]);
    end
    checks++;
    if (en_pulses - p0 !== 3 || en_multi !== m0) begin
      errors++; $display("FAIL b2b_enable got pulses %0d multi %0d want 3 0", en_pulses - p0, en_multi - m0);
    end
    checks++;
    if (hs_true - t0 !== 3) begin errors++; $display("FAIL b2b_results got %0d want 3", hs_true - t0); end
  endtask

  initial begin
    acc_init: begin end
    test_reset();
    test_equality();
    test_greater_less();
    test_reset_mid_wait();
    test_backpressure();
    test_timeout();
    test_noop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
